apple_video_fetch: RTL and testbench

Line fetch sequencer for the shadow video memory. On each line request it computes the Apple II interleaved base address for text/lores or hires, issues 20 sequential word reads on the video read port of the shadow memory, and unpacks each 32-bit return word into two 40-column entries (main and aux byte). Entries go to the renderer over a valid/ready stream. The block sits between the shadow memory's video read port and the scanline renderer.

---
 rtl/apple_video_fetch.sv | 168 ++++++++++++++++
 tb/tb_apple_video_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apple_video_fetch.sv
// Apple II line fetch: interleaved base address, 20 word reads, 40 (main,aux) columns on a valid/ready stream.
// First column three cycles after line start; reads throttle on FIFO room, outputs hold while pix_ready_i is low.

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];
   assign empty   = (count == '0);
endmodule

module apple_video_fetch #(
   parameter int FIFO_WORDS = 4
) (
   input  logic        clk_logic,
   input  logic        system_reset_n,
   input  logic        line_start_i,
   input  logic [7:0]  line_i,
   input  logic        text_mode_i,
   input  logic        mixed_mode_i,
   input  logic        hires_mode_i,
   input  logic        page2_i,
   input  logic        store80_i,
   output logic [15:0] video_address_o,
   output logic        video_rd_o,
   input  logic [31:0] video_data_i,
   output logic        pix_valid_o,
   input  logic        pix_ready_i,
   output logic [7:0]  pix_main_o,
   output logic [7:0]  pix_aux_o,
   output logic [5:0]  pix_col_o,
   output logic        pix_last_o,
   output logic        busy_o,
   output logic        line_done_o
);
   localparam int CW = $clog2(FIFO_WORDS) + 1;
   localparam logic [CW:0] FIFO_LIM = FIFO_WORDS[CW:0];

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [15:0]   base_q;
   logic [4:0]    rd_cnt;
   logic          rd_q;
   logic [5:0]    col_cnt;

   logic          start_vld, text_sel, hires_sel, pg;
   logic [4:0]    row;
   logic [15:0]   text_base, hires_base;
   logic [CW:0]   occ_sum;
   logic          pix_hs, last_hs, fifo_pop, fifo_empty;
   logic [31:0]   fifo_dat;
   logic [CW-1:0] fifo_count;

   assign start_vld = line_start_i && (line_i <= 8'd191);
   assign text_sel  = text_mode_i || (mixed_mode_i && (line_i >= 8'd160));
   assign hires_sel = !text_sel && hires_mode_i;
   assign pg        = page2_i && !store80_i;
   assign row       = line_i[7:3];

   // Lores shares the text layout; only hires uses the 1 KB-per-line-bit interleave.
   assign text_base  = (pg ? 16'h0800 : 16'h0400) + {6'b0, row[2:0], 7'b0}
                     + 16'(row[4:3]) * 16'd40;
   assign hires_base = (pg ? 16'h4000 : 16'h2000) + {3'b0, line_i[2:0], 10'b0}
                     + {6'b0, line_i[5:3], 7'b0} + 16'(line_i[7:6]) * 16'd40;

   // A read issued last cycle is counted against FIFO room until its data lands.
   assign occ_sum         = {1'b0, fifo_count} + {{CW{1'b0}}, rd_q};
   assign video_rd_o      = (state == FETCH) && !start_vld && (occ_sum < FIFO_LIM);
   assign video_address_o = base_q + {10'b0, rd_cnt, 1'b0};
   assign busy_o          = (state != IDLE);

   assign pix_valid_o = !fifo_empty;
   assign pix_col_o   = col_cnt;
   assign pix_last_o  = pix_valid_o && (col_cnt == 6'd39);
   assign pix_main_o  = !pix_valid_o ? 8'h00 : (col_cnt[0] ? fifo_dat[23:16] : fifo_dat[7:0]);
   assign pix_aux_o   = !pix_valid_o ? 8'h00 : (col_cnt[0] ? fifo_dat[31:24] : fifo_dat[15:8]);
   assign pix_hs      = pix_valid_o && pix_ready_i;
   assign fifo_pop    = pix_hs && col_cnt[0];
   assign last_hs     = pix_hs && pix_last_o && (state == DRAIN);

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_WORDS)) u_fifo (
      .clk      (clk_logic),
      .rst_n    (system_reset_n),
      .flush    (start_vld),
      .push     (rd_q),
      .push_dat (video_data_i),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .count    (fifo_count),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_vld) state_nxt = FETCH;
         FETCH:   if (start_vld) state_nxt = FETCH;
                  else if (video_rd_o && (rd_cnt == 5'd19)) state_nxt = DRAIN;
         DRAIN:   if (start_vld) state_nxt = FETCH;
                  else if (last_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_logic or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state       <= IDLE;
         base_q      <= '0;
         rd_cnt      <= '0;
         rd_q        <= 1'b0;
         col_cnt     <= '0;
         line_done_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         line_done_o <= last_hs;
         rd_q        <= video_rd_o;
         if (start_vld) begin
            base_q  <= hires_sel ? hires_base : text_base;
            rd_cnt  <= '0;
            col_cnt <= '0;
         end else begin
            if (video_rd_o) rd_cnt <= rd_cnt + 5'd1;
            if (pix_hs) col_cnt <= pix_last_o ? 6'd0 : col_cnt + 6'd1;
         end
      end
   end
endmodule

// File: tb/tb_apple_video_fetch.sv
// Directed bench for apple_video_fetch: address generation, unpacking, backpressure, restart and reset.
module tb_apple_video_fetch;
   localparam int FW = 4;

   logic        clk_logic = 1'b0;
   logic        system_reset_n = 1'b0;
   logic        line_start_i = 1'b0;
   logic [7:0]  line_i = 8'd0;
   logic        text_mode_i = 1'b0, mixed_mode_i = 1'b0, hires_mode_i = 1'b0;
   logic        page2_i = 1'b0, store80_i = 1'b0;
   logic [15:0] video_address_o;
   logic        video_rd_o;
   logic [31:0] video_data_i = 32'd0;
   logic        pix_valid_o;
   logic        pix_ready_i = 1'b1;
   logic [7:0]  pix_main_o, pix_aux_o;
   logic [5:0]  pix_col_o;
   logic        pix_last_o, busy_o, line_done_o;

   apple_video_fetch #(.FIFO_WORDS(FW)) dut (
      .clk_logic(clk_logic), .system_reset_n(system_reset_n),
      .line_start_i(line_start_i), .line_i(line_i),
      .text_mode_i(text_mode_i), .mixed_mode_i(mixed_mode_i), .hires_mode_i(hires_mode_i),
      .page2_i(page2_i), .store80_i(store80_i),
      .video_address_o(video_address_o), .video_rd_o(video_rd_o), .video_data_i(video_data_i),
      .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
      .pix_main_o(pix_main_o), .pix_aux_o(pix_aux_o), .pix_col_o(pix_col_o),
      .pix_last_o(pix_last_o), .busy_o(busy_o), .line_done_o(line_done_o)
   );

   always #5 clk_logic = ~clk_logic;

   int cyc = 0;
   always @(posedge clk_logic) cyc <= cyc + 1;

   int          checks = 0, failures = 0;
   int          t0 = 0, rd_count = 0, first_rd_rel = -1;
   logic [15:0] first_addr = 16'd0, last_addr = 16'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] mainf(input logic [15:0] a);
      if (a == 16'h4080) return 8'hAA;
      if (a == 16'h4081) return 8'hCC;
      return a[7:0] ^ {a[11:8], a[15:12]};
   endfunction

   function automatic logic [7:0] auxf(input logic [15:0] a);
      if (a == 16'h4080) return 8'hBB;
      if (a == 16'h4081) return 8'hDD;
      return mainf(a) ^ 8'hA5;
   endfunction

   function automatic logic [31:0] word_of(input logic [15:0] a);
      return {auxf(a + 16'd1), mainf(a + 16'd1), auxf(a), mainf(a)};
   endfunction

   // Memory model: data for a read seen in cycle n is presented throughout cycle n+1.
   initial begin
      logic        pend;
      logic [15:0] paddr;
      forever begin
         @(negedge clk_logic);
         pend  = video_rd_o;
         paddr = video_address_o;
         if (pend) begin
            if (rd_count == 0) begin
               first_addr   = paddr;
               first_rd_rel = cyc - t0;
            end
            last_addr = paddr;
            rd_count++;
         end
         @(posedge clk_logic);
         #1;
         video_data_i = pend ? word_of(paddr) : 32'hEEEE_EEEE;
      end
   end

   task automatic start_line(input logic [7:0] ln, input logic t, input logic m, input logic h,
                             input logic p2, input logic s80);
      @(posedge clk_logic);
      #1;
      line_i = ln; text_mode_i = t; mixed_mode_i = m; hires_mode_i = h;
      page2_i = p2; store80_i = s80; line_start_i = 1'b1;
      t0 = cyc; rd_count = 0; first_rd_rel = -1;
   endtask

   task automatic collect(input logic [15:0] base_in, input int stall_from, input int stall_len,
                          input int abort_rel, input int budget,
                          output int ncols, output int first_vld, output int done_rel,
                          output int ndone, output logic [15:0] pre_first, output int pre_cols);
      logic [15:0] base;
      int          rel;
      bit          aborted;
      base = base_in; aborted = 0;
      ncols = 0; first_vld = -1; done_rel = -1; ndone = 0; pre_first = 16'd0; pre_cols = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_logic);
         rel = cyc - t0;
         if (rel == 1) check("busy_c1", {31'd0, busy_o}, 32'd1);
         if (pix_valid_o && first_vld < 0) first_vld = rel;
         if (pix_valid_o && pix_ready_i) begin
            check("col", {26'd0, pix_col_o}, ncols);
            check("main", {24'd0, pix_main_o}, {24'd0, mainf(base + 16'(ncols))});
            check("aux", {24'd0, pix_aux_o}, {24'd0, auxf(base + 16'(ncols))});
            check("last", {31'd0, pix_last_o}, {31'd0, ncols == 39});
            ncols++;
         end
         if (stall_len > 0 && rel == stall_from + stall_len - 1) begin
            check("stall_vld", {31'd0, pix_valid_o}, 32'd1);
            check("stall_col", {26'd0, pix_col_o}, ncols);
            check("stall_main", {24'd0, pix_main_o}, {24'd0, mainf(base + 16'(ncols))});
            check("stall_rds", rd_count, FW);
         end
         if (line_done_o) begin
            ndone++;
            done_rel = rel;
         end
         if (done_rel >= 0 && ncols >= 40) break;
         @(posedge clk_logic);
         #1;
         line_start_i = 1'b0;
         rel = cyc - t0;
         pix_ready_i = !(stall_len > 0 && rel >= stall_from && rel < stall_from + stall_len);
         if (!aborted && rel == abort_rel) begin
            aborted = 1;
            pix_ready_i = 1'b0;
            pre_first = first_addr; pre_cols = ncols;
            line_i = 8'd10; text_mode_i = 1'b1; mixed_mode_i = 1'b0; line_start_i = 1'b1;
            t0 = cyc; rd_count = 0; first_rd_rel = -1;
            base = 16'h0480; ncols = 0; first_vld = -1;
         end
      end
      pix_ready_i = 1'b1;
   endtask

   initial begin
      int nc, fv, dr, nd, pc;
      logic [15:0] pf;

      repeat (3) @(posedge clk_logic);
      #1;
      check("rst_rd", {31'd0, video_rd_o}, 32'd0);
      check("rst_addr", {16'd0, video_address_o}, 32'd0);
      check("rst_vld", {31'd0, pix_valid_o}, 32'd0);
      check("rst_main", {24'd0, pix_main_o}, 32'd0);
      check("rst_col", {26'd0, pix_col_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, line_done_o}, 32'd0);
      system_reset_n = 1'b1;

      start_line(8'd191, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      collect(16'h3FD0, 0, 0, -1, 100, nc, fv, dr, nd, pf, pc);
      check("h191_first", {16'd0, first_addr}, 32'h3FD0);
      check("h191_lastaddr", {16'd0, last_addr}, 32'h3FF6);
      check("h191_rds", rd_count, 20);
      check("h191_rd_cyc", first_rd_rel, 1);
      check("h191_vld_cyc", fv, 3);
      check("h191_cols", nc, 40);
      check("h191_ndone", nd, 1);
      check("h191_done_by45", {31'd0, dr >= 4 && dr <= 45}, 32'd1);

      start_line(8'd64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      collect(16'h0428, 0, 0, -1, 100, nc, fv, dr, nd, pf, pc);
      check("t64_first", {16'd0, first_addr}, 32'h0428);
      check("t64_cols", nc, 40);

      start_line(8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      collect(16'h0400, 0, 0, -1, 100, nc, fv, dr, nd, pf, pc);
      check("t80_first", {16'd0, first_addr}, 32'h0400);
      check("t80_cols", nc, 40);

      start_line(8'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      collect(16'h4080, 0, 0, -1, 100, nc, fv, dr, nd, pf, pc);
      check("h8p2_first", {16'd0, first_addr}, 32'h4080);
      check("h8p2_cols", nc, 40);

      start_line(8'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      collect(16'h0628, 4, 30, -1, 150, nc, fv, dr, nd, pf, pc);
      check("stall_cols", nc, 40);
      check("stall_ndone", nd, 1);

      start_line(8'd160, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      collect(16'h0650, 0, 0, 20, 150, nc, fv, dr, nd, pf, pc);
      check("mix160_first", {16'd0, pf}, 32'h0650);
      check("abort_precols", pc, 17);
      check("abort_first", {16'd0, first_addr}, 32'h0480);
      check("abort_cols", nc, 40);
      check("abort_ndone", nd, 1);

      start_line(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk_logic);
         #1;
         line_start_i = 1'b0;
      end
      system_reset_n = 1'b0;
      #1;
      check("mrst_rd", {31'd0, video_rd_o}, 32'd0);
      check("mrst_addr", {16'd0, video_address_o}, 32'd0);
      check("mrst_vld", {31'd0, pix_valid_o}, 32'd0);
      check("mrst_main", {24'd0, pix_main_o}, 32'd0);
      check("mrst_aux", {24'd0, pix_aux_o}, 32'd0);
      check("mrst_last", {31'd0, pix_last_o}, 32'd0);
      check("mrst_busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(posedge clk_logic);
      #1;
      system_reset_n = 1'b1;
      repeat (5) @(negedge clk_logic);
      check("post_rst_vld", {31'd0, pix_valid_o}, 32'd0);
      check("post_rst_busy", {31'd0, busy_o}, 32'd0);

      start_line(8'd200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk_logic);
      #1;
      line_start_i = 1'b0;
      @(negedge clk_logic);
      check("l200_busy", {31'd0, busy_o}, 32'd0);
      check("l200_rd", {31'd0, video_rd_o}, 32'd0);
      @(negedge clk_logic);
      check("l200_busy2", {31'd0, busy_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
